// File: rtl/sprite_plotter_pkg.sv
// Shared constants, state encoding and sprite artwork for the sprite plotter.
// The sprite pattern is defined once here so the ROM stays a plain lookup.
package sprite_plotter_pkg;

    localparam int SPR_W = 10;
    localparam int SPR_H = 11;
    localparam int SCR_W = 160;
    localparam int SCR_H = 120;

    localparam logic [2:0] BG_COLOUR   = 3'b000;
    localparam logic [2:0] TRANSPARENT = 3'b101;

    localparam logic [7:0] HOME_X = 8'd0;
    localparam logic [6:0] HOME_Y = 7'd109;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // Sprite artwork: colour is the low 3 bits of row XOR col.
    function automatic logic [2:0] sprite_pixel(
        input logic [3:0] row,
        input logic [3:0] col
    );
        logic [3:0] p;
        p = row ^ col;
        return p[2:0];
    endfunction

endpackage

// File: rtl/sprite_rom.sv
// 110 x 3-bit sprite ROM, row-major (addr = row*10 + col), one-cycle latency.
// Ports: CLOCK, ResetN, addr[6:0] in; data[2:0] registered out.
module sprite_rom
    import sprite_plotter_pkg::*;
(
    input  logic       CLOCK,
    input  logic       ResetN,
    input  logic [6:0] addr,
    output logic [2:0] data
);

    logic [3:0] row;
    logic [3:0] col;

    always_comb begin
        row = 4'(addr / 7'd10);
        col = 4'(addr % 7'd10);
    end

    always_ff @(posedge CLOCK or negedge ResetN) begin
        if (!ResetN) data <= BG_COLOUR;
        else         data <= sprite_pixel(row, col);
    end

endmodule

// File: rtl/sprite_plotter.sv
// Erases the sprite at its old position and redraws it at the new one.
// Ports: CLOCK, ResetN, frameTick, posX/posY in; plotX/plotY/colour/plot/busy out.
module sprite_plotter
    import sprite_plotter_pkg::*;
(
    input  logic       CLOCK,
    input  logic       ResetN,
    input  logic       frameTick,
    input  logic [7:0] posX,
    input  logic [6:0] posY,
    output logic [7:0] plotX,
    output logic [6:0] plotY,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy
);

    localparam logic [3:0] COL_LAST = 4'(SPR_W - 1);
    localparam logic [3:0] ROW_LAST = 4'(SPR_H - 1);
    localparam logic [3:0] ROW_END  = 4'(SPR_H);
    localparam logic [8:0] X_LIM    = 9'(SCR_W);
    localparam logic [7:0] Y_LIM    = 8'(SCR_H);

    state_t     state, next_state;
    logic [3:0] row, col;
    logic [7:0] lat_x, last_x;
    logic [6:0] lat_y, last_y;
    logic       valid;
    logic       accept;
    logic       issue;
    logic       is_erase;
    logic       last_pix;
    logic [8:0] px;
    logic [7:0] py;
    logic [6:0] addr;
    logic [2:0] rom_q;
    logic       s2_valid, s2_erase, s2_onscreen;

    assign is_erase = (state == ERASE);
    assign last_pix = (row == ROW_LAST) && (col == COL_LAST);
    // DRAW runs one extra cycle (row == ROW_END) to drain the output stage.
    assign issue    = (state == ERASE || state == DRAW) && (row < ROW_END);
    assign busy     = (state != IDLE);

    always_ff @(posedge CLOCK or negedge ResetN) begin
        if (!ResetN) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (frameTick) begin
                    if (!valid) begin
                        next_state = DRAW;
                        accept     = 1'b1;
                    end else if ({posX, posY} != {last_x, last_y}) begin
                        next_state = ERASE;
                        accept     = 1'b1;
                    end
                end
            end
            ERASE: if (last_pix) next_state = DRAW;
            DRAW:  if (row == ROW_END) next_state = FLUSH;
            FLUSH: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Stage 1: pixel coordinates at full width so off-screen pixels never wrap.
    always_comb begin
        px   = {1'b0, (is_erase ? last_x : lat_x)} + {5'b0, col};
        py   = {1'b0, (is_erase ? last_y : lat_y)} + {4'b0, row};
        addr = 7'({3'b0, row} * 7'd10 + {3'b0, col});
    end

    always_ff @(posedge CLOCK or negedge ResetN) begin
        if (!ResetN) begin
            row <= '0;
            col <= '0;
        end else if (state != next_state) begin
            row <= '0;
            col <= '0;
        end else if (issue) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= row + 4'd1;
            end else begin
                col <= col + 4'd1;
            end
        end
    end

    always_ff @(posedge CLOCK or negedge ResetN) begin
        if (!ResetN) begin
            lat_x  <= '0;
            lat_y  <= '0;
            last_x <= HOME_X;
            last_y <= HOME_Y;
            valid  <= 1'b0;
        end else begin
            if (accept) begin
                lat_x <= posX;
                lat_y <= posY;
            end
            if (state == DRAW && next_state == FLUSH) begin
                last_x <= lat_x;
                last_y <= lat_y;
                valid  <= 1'b1;
            end
        end
    end

    sprite_rom u_rom (
        .CLOCK  (CLOCK),
        .ResetN (ResetN),
        .addr   (addr),
        .data   (rom_q)
    );

    // Stage 2: registered alongside the ROM output.
    always_ff @(posedge CLOCK or negedge ResetN) begin
        if (!ResetN) begin
            s2_valid    <= 1'b0;
            s2_erase    <= 1'b0;
            s2_onscreen <= 1'b0;
            plotX       <= '0;
            plotY       <= '0;
        end else begin
            s2_valid    <= issue;
            s2_erase    <= is_erase;
            s2_onscreen <= (px < X_LIM) && (py < Y_LIM);
            plotX       <= px[7:0];
            plotY       <= py[6:0];
        end
    end

    assign colour = (s2_valid && !s2_erase) ? rom_q : BG_COLOUR;
    assign plot   = s2_valid && s2_onscreen &&
                    (s2_erase || rom_q != TRANSPARENT);

endmodule

// File: tb/tb_sprite_plotter.sv
// Self-checking bench for sprite_plotter against a pixel-list reference model.
// Directed and random passes, mid-pass disturbance and mid-pass reset.
module tb_sprite_plotter;

    logic       CLOCK;
    logic       ResetN;
    logic       frameTick;
    logic [7:0] posX;
    logic [6:0] posY;
    logic [7:0] plotX;
    logic [6:0] plotY;
    logic [2:0] colour;
    logic       plot;
    logic       busy;

    int vectors;
    int miscompares;

    logic [7:0] m_lx;
    logic [6:0] m_ly;
    bit         m_valid;

    logic [17:0] exp_q[$];
    logic [17:0] obs_q[$];

    sprite_plotter dut (
        .CLOCK     (CLOCK),
        .ResetN    (ResetN),
        .frameTick (frameTick),
        .posX      (posX),
        .posY      (posY),
        .plotX     (plotX),
        .plotY     (plotY),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] o,
                         input logic [31:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Reference: list of visible pixels (x,y,colour) the pass must emit.
    task automatic model(input logic [7:0] x, input logic [6:0] y,
                         output int busy_exp);
        exp_q.delete();
        if (m_valid && x == m_lx && y == m_ly) begin
            busy_exp = 0;
            return;
        end
        busy_exp = m_valid ? 222 : 112;
        if (m_valid) begin
            for (int r = 0; r < 11; r++)
                for (int c = 0; c < 10; c++) begin
                    int ex, ey;
                    ex = int'(m_lx) + c;
                    ey = int'(m_ly) + r;
                    if (ex < 160 && ey < 120)
                        exp_q.push_back({8'(ex), 7'(ey), 3'b000});
                end
        end
        for (int r = 0; r < 11; r++)
            for (int c = 0; c < 10; c++) begin
                int ex, ey, col;
                ex  = int'(x) + c;
                ey  = int'(y) + r;
                col = (r ^ c) & 7;
                if (ex < 160 && ey < 120 && col != 5)
                    exp_q.push_back({8'(ex), 7'(ey), 3'(col)});
            end
        m_lx    = x;
        m_ly    = y;
        m_valid = 1'b1;
    endtask

    task automatic do_pass(input logic [7:0] x, input logic [6:0] y,
                           input bit disturb, output int bc,
                           output int stray);
        obs_q.delete();
        bc        = 0;
        stray     = 0;
        posX      = x;
        posY      = y;
        frameTick = 1'b1;
        @(negedge CLOCK);
        frameTick = 1'b0;
        for (int c = 0; c < 240; c++) begin
            if (busy) bc++;
            if (plot) begin
                obs_q.push_back({plotX, plotY, colour});
                if (!busy) stray++;
            end
            if (disturb && c == 50) begin
                frameTick = 1'b1;
                posX      = x + 8'd3;
            end else begin
                frameTick = 1'b0;
            end
            @(negedge CLOCK);
        end
    endtask

    task automatic run(input logic [7:0] x, input logic [6:0] y,
                       input bit disturb, input string name);
        int be, bc, stray, n;
        model(x, y, be);
        do_pass(x, y, disturb, bc, stray);
        check({name, ".busy_cycles"}, bc, be);
        check({name, ".stray_plot"}, stray, 0);
        check({name, ".pixel_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s.pixel%0d", name, i), 32'(obs_q[i]),
                  32'(exp_q[i]));
    endtask

    initial begin
        logic [7:0] rx;
        logic [6:0] ry;
        vectors     = 0;
        miscompares = 0;
        m_valid     = 1'b0;
        m_lx        = 8'd0;
        m_ly        = 7'd109;
        ResetN      = 1'b1;
        frameTick   = 1'b0;
        posX        = '0;
        posY        = '0;

        #1 ResetN = 1'b0;
        #2;
        check("reset.plot", plot, 0);
        check("reset.busy", busy, 0);
        check("reset.plotX", plotX, 0);
        check("reset.plotY", plotY, 0);
        check("reset.colour", colour, 0);
        repeat (2) @(negedge CLOCK);
        ResetN = 1'b1;
        @(negedge CLOCK);

        run(8'd0, 7'd109, 1'b0, "first_draw");
        run(8'd1, 7'd109, 1'b0, "move_right");
        run(8'd1, 7'd109, 1'b0, "unchanged");
        run(8'd155, 7'd115, 1'b0, "edge_clip");
        run(8'd40, 7'd20, 1'b1, "disturbed");

        for (int k = 0; k < 4; k++) begin
            rx = 8'($urandom_range(159, 0));
            ry = 7'($urandom_range(119, 0));
            run(rx, ry, 1'b0, $sformatf("random%0d", k));
        end

        posX      = (m_lx == 8'd20) ? 8'd21 : 8'd20;
        posY      = 7'd30;
        frameTick = 1'b1;
        @(negedge CLOCK);
        frameTick = 1'b0;
        repeat (170) @(negedge CLOCK);
        check("midpass.busy_before", busy, 1);
        #2 ResetN = 1'b0;
        #1;
        check("midpass.plot", plot, 0);
        check("midpass.busy", busy, 0);
        check("midpass.plotX", plotX, 0);
        check("midpass.colour", colour, 0);
        @(negedge CLOCK);
        ResetN  = 1'b1;
        m_valid = 1'b0;
        m_lx    = 8'd0;
        m_ly    = 7'd109;
        @(negedge CLOCK);

        run(8'd70, 7'd50, 1'b0, "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
